// File: rtl/simd_upstream_cntl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simd_upstream_cntl_pkg
// Purpose  : Shared constants and FSM encoding for the SIMD upstream controller.
// Revision : 1.0 - initial release
// ============================================================================
package simd_upstream_cntl_pkg;

    localparam int C_DEF_NUM_LANES  = 32;
    localparam int C_DEF_LANE_WIDTH = 32;
    localparam int C_DEF_TAG_WIDTH  = 4;

    // Header beat layout: lane count in one byte, tag in the low bits.
    localparam int C_HDR_CNT_LSB = 8;
    localparam int C_HDR_CNT_MSB = 15;
    localparam int C_HDR_TAG_LSB = 0;

    localparam logic [1:0] C_GUARD_LOAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HDR     = 2'd2,
        ST_DATA    = 2'd3
    } scntl_state_t;

endpackage : simd_upstream_cntl_pkg
`default_nettype wire

// File: rtl/simd_lane_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : simd_lane_snapshot
// Purpose  : Holds a frozen copy of all lane results plus tag; muxes one lane out.
// Revision : 1.0 - initial release
// ============================================================================
module simd_lane_snapshot
    import simd_upstream_cntl_pkg::*;
#(
    parameter int NUM_LANES  = C_DEF_NUM_LANES,
    parameter int LANE_WIDTH = C_DEF_LANE_WIDTH,
    parameter int TAG_WIDTH  = C_DEF_TAG_WIDTH,
    parameter int IDX_W      = $clog2(NUM_LANES)
) (
    input  logic                            clk,
    input  logic                            reset_poweron_n,
    input  logic                            i_capture,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] i_regs,
    input  logic [TAG_WIDTH-1:0]            i_tag,
    input  logic [IDX_W-1:0]                i_sel,
    output logic [LANE_WIDTH-1:0]           o_lane,
    output logic [TAG_WIDTH-1:0]            o_tag
);

    // Packed so lane i lines up with bits [i*LANE_WIDTH +: LANE_WIDTH] of the input bus.
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0] r_snap;
    logic [TAG_WIDTH-1:0]                 r_tag;

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            r_snap <= '0;
            r_tag  <= '0;
        end else if (i_capture) begin
            r_snap <= i_regs;
            r_tag  <= i_tag;
        end
    end

    assign o_lane = r_snap[i_sel];
    assign o_tag  = r_tag;

endmodule : simd_lane_snapshot
`default_nettype wire

// File: rtl/simd_upstream_cntl.sv
`default_nettype none
// ============================================================================
// Module   : simd_upstream_cntl
// Purpose  : Snapshots a full set of SIMD lane results and streams them upstream
//            as one header beat followed by one beat per lane.
// Revision : 1.0 - initial release
// ============================================================================
module simd_upstream_cntl
    import simd_upstream_cntl_pkg::*;
#(
    parameter int NUM_LANES  = C_DEF_NUM_LANES,
    parameter int LANE_WIDTH = C_DEF_LANE_WIDTH,
    parameter int TAG_WIDTH  = C_DEF_TAG_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset_poweron_n,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] simd__scntl__regs,
    input  logic [NUM_LANES-1:0]            simd__scntl__regs_valid,
    input  logic [TAG_WIDTH-1:0]            simd__scntl__tag,
    output logic                            scntl__simd__regs_complete,
    output logic                            scntl__sui__valid,
    output logic                            scntl__sui__sop,
    output logic                            scntl__sui__eop,
    output logic [LANE_WIDTH-1:0]           scntl__sui__data,
    input  logic                            sui__scntl__ready
);

    localparam int               IDX_W      = $clog2(NUM_LANES);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_LANES - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
    localparam logic [7:0]       C_LANE_CNT = 8'(NUM_LANES);

    scntl_state_t          r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [1:0]            r_guard;

    logic                  w_arm;
    logic                  w_fire;
    logic                  w_capture;
    logic [IDX_W-1:0]      w_sel;
    logic [LANE_WIDTH-1:0] w_lane;
    logic [LANE_WIDTH-1:0] w_hdr;
    logic [TAG_WIDTH-1:0]  w_tag;

    assign w_arm     = (&simd__scntl__regs_valid) && (r_guard == 2'd0);
    assign w_fire    = scntl__sui__valid && sui__scntl__ready;
    assign w_capture = (r_state == ST_IDLE) && w_arm;

    // The mux looks one lane ahead so the data register loads the beat that follows a handshake.
    assign w_sel = ((r_state == ST_DATA) && (r_idx != C_LAST_IDX)) ? (r_idx + C_IDX_ONE) : '0;

    always_comb begin
        w_hdr = '0;
        w_hdr[C_HDR_CNT_MSB:C_HDR_CNT_LSB]   = C_LANE_CNT;
        w_hdr[C_HDR_TAG_LSB +: TAG_WIDTH]    = w_tag;
    end

    simd_lane_snapshot #(
        .NUM_LANES  (NUM_LANES),
        .LANE_WIDTH (LANE_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .IDX_W      (IDX_W)
    ) u_snapshot (
        .clk             (clk),
        .reset_poweron_n (reset_poweron_n),
        .i_capture       (w_capture),
        .i_regs          (simd__scntl__regs),
        .i_tag           (simd__scntl__tag),
        .i_sel           (w_sel),
        .o_lane          (w_lane),
        .o_tag           (w_tag)
    );

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            r_state                    <= ST_IDLE;
            r_idx                      <= '0;
            r_guard                    <= '0;
            scntl__simd__regs_complete <= 1'b0;
            scntl__sui__valid          <= 1'b0;
            scntl__sui__sop            <= 1'b0;
            scntl__sui__eop            <= 1'b0;
            scntl__sui__data           <= '0;
        end else begin
            scntl__simd__regs_complete <= 1'b0;

            // Guard covers the wrapper's registered clear so a stale all-ones mask cannot re-arm.
            if (scntl__simd__regs_complete) begin
                r_guard <= C_GUARD_LOAD;
            end else if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_arm) begin
                        r_state                    <= ST_CAPTURE;
                        scntl__simd__regs_complete <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_state           <= ST_HDR;
                    scntl__sui__valid <= 1'b1;
                    scntl__sui__sop   <= 1'b1;
                    scntl__sui__eop   <= 1'b0;
                    scntl__sui__data  <= w_hdr;
                end
                ST_HDR: begin
                    if (w_fire) begin
                        r_state          <= ST_DATA;
                        r_idx            <= '0;
                        scntl__sui__sop  <= 1'b0;
                        scntl__sui__eop  <= (C_LAST_IDX == '0);
                        scntl__sui__data <= w_lane;
                    end
                end
                ST_DATA: begin
                    if (w_fire) begin
                        if (r_idx == C_LAST_IDX) begin
                            r_state           <= ST_IDLE;
                            r_idx             <= '0;
                            scntl__sui__valid <= 1'b0;
                            scntl__sui__eop   <= 1'b0;
                            scntl__sui__data  <= '0;
                        end else begin
                            r_idx            <= r_idx + C_IDX_ONE;
                            scntl__sui__eop  <= ((r_idx + C_IDX_ONE) == C_LAST_IDX);
                            scntl__sui__data <= w_lane;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : simd_upstream_cntl
`default_nettype wire

// File: tb/tb_simd_upstream_cntl.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_upstream_cntl
// Purpose  : Directed self-checking bench for simd_upstream_cntl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_upstream_cntl;

    localparam int NUM_LANES  = 32;
    localparam int LANE_WIDTH = 32;
    localparam int TAG_WIDTH  = 4;

    logic                            clk;
    logic                            reset_poweron_n;
    logic [NUM_LANES*LANE_WIDTH-1:0] regs;
    logic [NUM_LANES-1:0]            regs_valid;
    logic [TAG_WIDTH-1:0]            tag;
    logic                            complete;
    logic                            valid;
    logic                            sop;
    logic                            eop;
    logic [LANE_WIDTH-1:0]           data;
    logic                            ready;

    int n_cmp  = 0;
    int n_fail = 0;
    int k;
    int cyc;

    simd_upstream_cntl #(
        .NUM_LANES  (NUM_LANES),
        .LANE_WIDTH (LANE_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) dut (
        .clk                        (clk),
        .reset_poweron_n            (reset_poweron_n),
        .simd__scntl__regs          (regs),
        .simd__scntl__regs_valid    (regs_valid),
        .simd__scntl__tag           (tag),
        .scntl__simd__regs_complete (complete),
        .scntl__sui__valid          (valid),
        .scntl__sui__sop            (sop),
        .scntl__sui__eop            (eop),
        .scntl__sui__data           (data),
        .sui__scntl__ready          (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_lanes(input logic [31:0] base);
        for (int i = 0; i < NUM_LANES; i++) begin
            regs[i*LANE_WIDTH +: LANE_WIDTH] = base + 32'(i);
        end
    endtask

    // {sop, eop, data} of beat k: k==0 is the header, k>=1 carries lane k-1.
    function automatic logic [33:0] beat_exp(input int kk, input logic [31:0] base, input logic [3:0] tg);
        if (kk == 0) begin
            return {1'b1, 1'b0, 32'h0000_2000 | {28'd0, tg}};
        end
        return {1'b0, (kk == NUM_LANES), base + 32'(kk - 1)};
    endfunction

    task automatic trigger(input logic [31:0] base, input logic [3:0] tg, input bit keep);
        int  c    = 0;
        bit  seen = 1'b0;
        set_lanes(base);
        tag        = tg;
        regs_valid = '1;
        while (!seen && c < 8) begin
            @(negedge clk);
            c++;
            if (complete) seen = 1'b1;
        end
        check("complete_seen", {63'd0, seen}, 64'd1);
        check("capture_latency", 64'(c), 64'd1);
        if (!keep) regs_valid = '0;
    endtask

    task automatic run_packet(input logic [31:0] base, input logic [3:0] tg, input bit rnd,
                              input int chg_k, input logic [31:0] new_base, input logic [3:0] new_tg);
        int kk      = 0;
        int c       = 0;
        int cmpl    = 0;
        bit started = 1'b0;
        while (kk <= NUM_LANES && c < 500) begin
            @(negedge clk);
            c++;
            if (complete) cmpl++;
            if (valid) begin
                started = 1'b1;
                check($sformatf("beat%0d", kk), {30'd0, sop, eop, data}, {30'd0, beat_exp(kk, base, tg)});
            end else if (started) begin
                check("valid_mid_pkt", {63'd0, valid}, 64'd1);
            end
            if (kk == chg_k) begin
                set_lanes(new_base);
                tag = new_tg;
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid && ready) kk++;
        end
        check("pkt_beats", 64'(kk), 64'(NUM_LANES + 1));
        check("pkt_complete_pulses", 64'(cmpl), 64'd0);
        @(negedge clk);
        check("post_pkt_idle", {60'd0, valid, sop, eop, complete}, 64'd0);
    endtask

    initial begin
        reset_poweron_n = 1'b0;
        regs            = '0;
        regs_valid      = '0;
        tag             = '0;
        ready           = 1'b0;

        // Reset state
        #7;
        check("reset_outputs", {28'd0, valid, sop, eop, complete, data}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_poweron_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {62'd0, valid, complete}, 64'd0);

        // Basic packet, ready held high: header 0x2005 then 0x100..0x11F
        ready = 1'b1;
        trigger(32'h100, 4'h5, 1'b0);
        run_packet(32'h100, 4'h5, 1'b0, -1, 32'h0, 4'h0);

        // Random back-pressure
        trigger(32'h200, 4'hA, 1'b0);
        run_packet(32'h200, 4'hA, 1'b1, -1, 32'h0, 4'h0);

        // Partial valid mask never starts a transfer
        ready = 1'b1;
        set_lanes(32'h300);
        tag        = 4'h3;
        regs_valid = 32'h7FFF_FFFF;
        repeat (100) begin
            @(negedge clk);
            check("partial_mask_idle", {62'd0, valid, complete}, 64'd0);
        end
        regs_valid[31] = 1'b1;
        @(negedge clk);
        check("bit31_complete", {62'd0, valid, complete}, 64'd1);
        regs_valid = '0;
        run_packet(32'h300, 4'h3, 1'b0, -1, 32'h0, 4'h0);

        // Inputs change mid-packet (at lane 10): old snapshot continues, next packet has new data
        trigger(32'h400, 4'h6, 1'b0);
        run_packet(32'h400, 4'h6, 1'b0, 11, 32'h500, 4'h7);
        trigger(32'h500, 4'h7, 1'b0);
        run_packet(32'h500, 4'h7, 1'b0, -1, 32'h0, 4'h0);

        // Wrapper never clears: no re-arm during packet, then IDLE and CAPTURE on the next cycle
        trigger(32'h700, 4'h2, 1'b1);
        run_packet(32'h700, 4'h2, 1'b0, -1, 32'h0, 4'h0);
        @(negedge clk);
        check("rearm_after_idle", {62'd0, valid, complete}, 64'd1);
        regs_valid = '0;
        run_packet(32'h700, 4'h2, 1'b0, -1, 32'h0, 4'h0);

        // Reset while stalled on lane 17
        ready = 1'b1;
        trigger(32'h600, 4'h9, 1'b1);
        k   = 0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (valid && k == 18) break;
            if (valid) k++;
        end
        ready = 1'b0;
        check("lane17_beat", {30'd0, sop, eop, data}, {30'd0, beat_exp(18, 32'h600, 4'h9)});
        @(negedge clk);
        check("lane17_stall_hold", {29'd0, valid, sop, eop, data}, {29'd0, 1'b1, beat_exp(18, 32'h600, 4'h9)});
        #2;
        reset_poweron_n = 1'b0;
        #1;
        check("async_reset_outputs", {28'd0, valid, sop, eop, complete, data}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_poweron_n = 1'b1;
        ready           = 1'b1;
        trigger(32'h600, 4'h9, 1'b0);
        run_packet(32'h600, 4'h9, 1'b0, -1, 32'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_simd_upstream_cntl
`default_nettype wire
